pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Centralised hazard and pipeline-control unit for the 5-stage RISC-V core.
- Generates PC/IF-ID write enables, per-stage bubble/flush controls and redirect select, covering:
  - load-use stalls;
  - multi-cycle EX operations of configurable latency;
  - taken-branch flush of configurable depth.
- Sits beside the forwarding unit and drives the enables of the stage pipeline registers.

Parameters:
REG_ADDR_W, 5, register-index width
MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal 2..255
FLUSH_DEPTH, 2, younger stages squashed on taken branch: 1=IF/ID only, 2=+ID/EX, 3=+EX/MEM (branch resolved in MEM)
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
id_rs1_i  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2_i  in  REG_ADDR_W  rs2 of instruction in ID
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
ex_rd_i  in  REG_ADDR_W  rd of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_mc_i  in  1  EX holds a multi-cycle op; held high while the op sits in EX
br_taken_i  in  1  taken branch resolved this cycle
pc_write_o  out  1  PC update enable
if_id_write_o  out  1  IF/ID register enable
if_id_flush_o  out  1  IF/ID loads NOP
id_ex_write_o  out  1  ID/EX register enable
id_ex_bubble_o  out  1  ID/EX loads zero controls
ex_mem_bubble_o  out  1  EX/MEM loads zero controls
pc_sel_o  out  1  1 selects branch target
busy_o  out  1  FSM in MC_BUSY
stall_cnt_o  out  CNT_W  stalled-cycle count
flush_cnt_o  out  CNT_W  taken-branch count

Behaviour:
- States: RUN, MC_BUSY. Down-counter cnt is 8 bits.
- Reset (rst_i low, async):
  - State and registers: state=RUN, cnt=0, both perf counters=0.
  - Outputs with idle inputs: pc_write_o=1, if_id_write_o=1, id_ex_write_o=1, all other outputs 0.
- Outputs are combinational from state, cnt and inputs; the only registered items are state, cnt and the perf counters.
- Load-use hazard, evaluated in RUN only:
  - LU = ex_mem_read_i & (ex_rd_i!=0) & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
  - LU gives pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for exactly that cycle. No state change.
- Multi-cycle op:
  - In RUN, ex_mc_i=1 gives MC stall: pc_write_o=0, if_id_write_o=0, id_ex_write_o=0, ex_mem_bubble_o=1.
  - If MC_LAT==2, next state is RUN. Otherwise next state is MC_BUSY with cnt=MC_LAT-2.
  - In MC_BUSY: same stall outputs, busy_o=1, cnt decrements each cycle. When cnt==1, next state is RUN.
  - Total stalled cycles per op = MC_LAT-1. The op leaves EX at the edge ending the last stall cycle.
  - ex_mc_i is ignored in MC_BUSY and in the first RUN cycle after exit, since the next instruction has just entered EX.
  - If LU and ex_mc_i are both asserted in RUN, the MC stall takes precedence. LU is re-evaluated after exit.
- Taken branch:
  - br_taken_i=1 gives pc_sel_o=1 and pc_write_o=1.
  - It also gives if_id_flush_o=1, id_ex_bubble_o=1 if FLUSH_DEPTH>=2, and ex_mem_bubble_o=1 if FLUSH_DEPTH==3.
  - Branch overrides LU and MC stalls in the same cycle; the dependent or younger instruction is squashed.
  - If it arrives in MC_BUSY with FLUSH_DEPTH==3: abort the op, next state RUN, cnt=0.
  - If it arrives in MC_BUSY with FLUSH_DEPTH<3: illegal; the simulation assertion fires and the input is ignored.
- Reset mid-operation: immediate return to RUN; the pending multi-cycle stall is discarded.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments on every cycle with pc_write_o=0.
  - flush_cnt_o increments on every br_taken_i cycle.
  - Both counters saturate at all-ones and clear on reset.
- Not defined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset release with idle inputs -> pc_write_o=1, if_id_write_o=1, id_ex_write_o=1, all others 0.
- Load x5 in EX, ID uses rs2=x5 -> one cycle with pc_write_o=0 and id_ex_bubble_o=1, then normal flow.
- Same case with ex_rd_i=0 -> no stall.
- MC_LAT=4, ex_mc_i held 4 cycles -> stall in cycles 0..2, busy_o in cycles 1..2, RUN in cycle 3.
- MC_LAT=2 -> 1-cycle stall, busy_o never asserted.
- FLUSH_DEPTH=2, br_taken_i coincident with LU -> pc_sel_o=1, if_id_flush_o=1, id_ex_bubble_o=1, pc_write_o=1, ex_mem_bubble_o=0.
- FLUSH_DEPTH=3, br_taken_i in second MC_BUSY cycle -> ex_mem_bubble_o=1, state RUN next cycle.
- With HAZARD_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturates).
- rst_i low mid MC_BUSY -> busy_o=0 immediately and counters cleared.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage core: combinational stall, bubble, flush and redirect decode.
// Holds only RUN/MC_BUSY state and a countdown. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MC_LAT      = 4,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_mc_i,
   input  logic                  br_taken_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_write_o,
   output logic                  id_ex_bubble_o,
   output logic                  ex_mem_bubble_o,
   output logic                  pc_sel_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   typedef enum logic [0:0] {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       load_use;
   logic       mc_stall;
   logic       br_ok;

   assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                     ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

   // In RUN a non-zero cnt marks the cycle right after an op left EX, so ex_mc_i is stale.
   assign mc_stall = (state_q == MC_BUSY) || (ex_mc_i && (cnt_q == '0));
   assign br_ok    = br_taken_i && ((state_q == RUN) || (FLUSH_DEPTH == 3));

   always_comb begin
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b0;
      id_ex_write_o   = 1'b1;
      id_ex_bubble_o  = 1'b0;
      ex_mem_bubble_o = 1'b0;
      pc_sel_o        = 1'b0;
      busy_o          = (state_q == MC_BUSY);
      if (br_ok) begin
         pc_sel_o        = 1'b1;
         if_id_flush_o   = 1'b1;
         id_ex_bubble_o  = (FLUSH_DEPTH >= 2);
         ex_mem_bubble_o = (FLUSH_DEPTH == 3);
      end else if (mc_stall) begin
         pc_write_o      = 1'b0;
         if_id_write_o   = 1'b0;
         id_ex_write_o   = 1'b0;
         ex_mem_bubble_o = 1'b1;
      end else if (load_use) begin
         pc_write_o      = 1'b0;
         if_id_write_o   = 1'b0;
         id_ex_bubble_o  = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            cnt_d = '0;
            if (!br_taken_i && ex_mc_i && (cnt_q == '0)) begin
               if (MC_LAT == 2) begin
                  cnt_d = 8'd1;
               end else begin
                  state_d = MC_BUSY;
                  cnt_d   = 8'(MC_LAT - 2);
               end
            end
         end
         MC_BUSY: begin
            if (br_taken_i && (FLUSH_DEPTH == 3)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt_q == 8'd1) begin
               state_d = RUN;
               cnt_d   = 8'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (br_taken_i && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

   // With shallow flush the branch cannot be in MEM while an op occupies EX.
   br_in_busy_legal: assert property (@(posedge clk_i) disable iff (!rst_i)
      !((state_q == MC_BUSY) && br_taken_i && (FLUSH_DEPTH < 3)));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share stimulus; vector table, corner sequences, random vs model.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam int LAT [3] = '{4, 2, 4};
   localparam int FD  [3] = '{2, 3, 3};
   localparam int CW  [3] = '{4, 16, 16};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, ex_mc, br;
   logic [2:0] brv;

   logic [7:0]  got [3];
   logic [15:0] sc_got [3];
   logic [15:0] fc_got [3];

   logic        pcw_a, ifw_a, fl_a, idw_a, bub_a, emb_a, sel_a, busy_a;
   logic        pcw_b, ifw_b, fl_b, idw_b, bub_b, emb_b, sel_b, busy_b;
   logic        pcw_c, ifw_c, fl_c, idw_c, bub_c, emb_c, sel_c, busy_c;
   logic [3:0]  sc_a, fc_a;
   logic [15:0] sc_b, fc_b, sc_c, fc_c;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(4), .FLUSH_DEPTH(2), .CNT_W(4)) u_a (
      .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1),
      .id_use_rs2_i(u2), .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_mc_i(ex_mc), .br_taken_i(brv[0]),
      .pc_write_o(pcw_a), .if_id_write_o(ifw_a), .if_id_flush_o(fl_a), .id_ex_write_o(idw_a),
      .id_ex_bubble_o(bub_a), .ex_mem_bubble_o(emb_a), .pc_sel_o(sel_a), .busy_o(busy_a),
      .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(2), .FLUSH_DEPTH(3), .CNT_W(16)) u_b (
      .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1),
      .id_use_rs2_i(u2), .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_mc_i(ex_mc), .br_taken_i(brv[1]),
      .pc_write_o(pcw_b), .if_id_write_o(ifw_b), .if_id_flush_o(fl_b), .id_ex_write_o(idw_b),
      .id_ex_bubble_o(bub_b), .ex_mem_bubble_o(emb_b), .pc_sel_o(sel_b), .busy_o(busy_b),
      .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(4), .FLUSH_DEPTH(3), .CNT_W(16)) u_c (
      .clk_i(clk), .rst_i(rst_n), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1),
      .id_use_rs2_i(u2), .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_mc_i(ex_mc), .br_taken_i(brv[2]),
      .pc_write_o(pcw_c), .if_id_write_o(ifw_c), .if_id_flush_o(fl_c), .id_ex_write_o(idw_c),
      .id_ex_bubble_o(bub_c), .ex_mem_bubble_o(emb_c), .pc_sel_o(sel_c), .busy_o(busy_c),
      .stall_cnt_o(sc_c), .flush_cnt_o(fc_c));

   // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, pc_sel, busy}
   assign got[0] = {pcw_a, ifw_a, fl_a, idw_a, bub_a, emb_a, sel_a, busy_a};
   assign got[1] = {pcw_b, ifw_b, fl_b, idw_b, bub_b, emb_b, sel_b, busy_b};
   assign got[2] = {pcw_c, ifw_c, fl_c, idw_c, bub_c, emb_c, sel_c, busy_c};
   assign sc_got[0] = {12'd0, sc_a};
   assign fc_got[0] = {12'd0, fc_a};
   assign sc_got[1] = sc_b;
   assign fc_got[1] = fc_b;
   assign sc_got[2] = sc_c;
   assign fc_got[2] = fc_c;

   // Reference model: stall cycles still owed by the op in EX, a stale-ex_mc flag, and counter values.
   int rem  [3];
   bit skip [3];
   int scnt [3];
   int fcnt [3];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [7:0] exp_out(input int k, input logic b);
      logic busy, lu, pcw, ifw, fl, idw, bub, emb, sel;
      busy = (rem[k] > 0);
      lu   = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      pcw = 1; ifw = 1; fl = 0; idw = 1; bub = 0; emb = 0; sel = 0;
      if (b) begin
         sel = 1; fl = 1; bub = (FD[k] >= 2); emb = (FD[k] == 3);
      end else if (busy || (ex_mc && !skip[k])) begin
         pcw = 0; ifw = 0; idw = 0; emb = 1;
      end else if (lu) begin
         pcw = 0; ifw = 0; bub = 1;
      end
      return {pcw, ifw, fl, idw, bub, emb, sel, busy};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         rem[k] = 0; skip[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
   endtask

   // Apply per-DUT branch (masked where it would be illegal), then check all DUTs at the falling edge.
   task automatic sample();
      for (int k = 0; k < 3; k++) brv[k] = br && !(rem[k] > 0 && FD[k] < 3);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("out[%0d]", k), {24'd0, got[k]}, {24'd0, exp_out(k, brv[k])});
         chk($sformatf("stall_cnt[%0d]", k), {16'd0, sc_got[k]}, PERF ? scnt[k] : 0);
         chk($sformatf("flush_cnt[%0d]", k), {16'd0, fc_got[k]}, PERF ? fcnt[k] : 0);
      end
   endtask

   task automatic advance();
      int mx;
      logic [7:0] e;
      for (int k = 0; k < 3; k++) begin
         e  = exp_out(k, brv[k]);
         mx = (1 << CW[k]) - 1;
         if (!e[7] && scnt[k] < mx) scnt[k]++;
         if (brv[k] && fcnt[k] < mx) fcnt[k]++;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (brv[k]) begin
            rem[k] = 0; skip[k] = 0;
         end else if (rem[k] > 0) begin
            rem[k]--;
            if (rem[k] == 0) skip[k] = 1;
         end else if (ex_mc && !skip[k]) begin
            rem[k] = LAT[k] - 2; skip[k] = (LAT[k] == 2);
         end else begin
            skip[k] = 0;
         end
      end
      #1;
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; ex_mc = 0; br = 0;
   endtask

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11010000};
      vt[1] = '{"lu_rs2_x5",     5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00011000};
      vt[2] = '{"after_lu",      5'd1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11010000};
      vt[3] = '{"lu_rd_x0",      5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b11010000};
      vt[4] = '{"lu_rs1_x7",     5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'b00011000};
      vt[5] = '{"rs1_not_used",  5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 8'b11010000};
      vt[6] = '{"br_with_lu",    5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'b11111010};
      vt[7] = '{"br_alone",      5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b11111010};

      idle();
      brv = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      sample();
      chk("reset_outputs_a", {24'd0, got[0]}, 32'h000000D0);
      rst_n = 1;
      advance();

      for (int i = 0; i < 8; i++) begin
         rs1 = vt[i].rs1; rs2 = vt[i].rs2; rd = vt[i].rd;
         u1 = vt[i].u1; u2 = vt[i].u2; mr = vt[i].mr; br = vt[i].br; ex_mc = 0;
         sample();
         chk({"vec_", vt[i].name}, {24'd0, got[0]}, {24'd0, vt[i].exp});
         advance();
      end
      idle();
      sample(); advance();

      // ex_mc held 4 cycles: LAT4 stalls cycles 0..2 with busy 1..2; LAT2 stalls only cycle 0.
      ex_mc = 1;
      for (int c = 0; c < 4; c++) begin
         sample();
         chk($sformatf("mc4_pcw_c%0d", c), {31'd0, pcw_a}, (c < 3) ? 0 : 1);
         chk($sformatf("mc4_busy_c%0d", c), {31'd0, busy_a}, (c == 1 || c == 2) ? 1 : 0);
         if (c < 2) begin
            chk($sformatf("mc2_pcw_c%0d", c), {31'd0, pcw_b}, (c == 0) ? 0 : 1);
            chk($sformatf("mc2_busy_c%0d", c), {31'd0, busy_b}, 0);
         end
         advance();
      end
      idle();
      repeat (3) begin sample(); advance(); end

      // Branch in second MC_BUSY cycle aborts the op when the flush reaches EX/MEM.
      ex_mc = 1;
      sample(); advance();
      sample(); advance();
      br = 1;
      sample();
      chk("abort_emb", {31'd0, emb_c}, 1);
      chk("abort_sel", {31'd0, sel_c}, 1);
      chk("abort_pcw", {31'd0, pcw_c}, 1);
      advance();
      idle();
      sample();
      chk("abort_run_next", {31'd0, busy_c}, 0);
      advance();
      repeat (3) begin sample(); advance(); end

      // 20 load-use stalls saturate the 4-bit counter.
      rs2 = 5; u2 = 1; rd = 5; mr = 1;
      repeat (20) begin sample(); advance(); end
      sample();
      chk("stall_sat", {28'd0, sc_a}, PERF ? 15 : 0);
      advance();
      idle();

      for (int i = 0; i < 400; i++) begin
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
         u1 = 1'($urandom); u2 = 1'($urandom); mr = 1'($urandom);
         ex_mc = ($urandom_range(0, 5) == 0);
         br = ($urandom_range(0, 7) == 0);
         sample(); advance();
      end
      idle();

      // Reset while busy: outputs and counters clear without waiting for a clock.
      ex_mc = 1;
      sample(); advance();
      sample(); advance();
      ex_mc = 0;
      #2;
      chk("pre_rst_busy", {31'd0, busy_a}, 1);
      rst_n = 0;
      #1;
      chk("rst_busy_a", {31'd0, busy_a}, 0);
      chk("rst_pcw_a", {31'd0, pcw_a}, 1);
      chk("rst_stall_cnt_a", {28'd0, sc_a}, 0);
      chk("rst_flush_cnt_a", {28'd0, fc_a}, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      repeat (4) begin sample(); advance(); end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
